// File: rtl/turtle_debug_scanner.sv
// Debug memory scanner: walks a register, dmem or imem window through the CPU
// debug read ports and streams one word per handshake.
module turtle_debug_scanner #(
  parameter int DATA_W         = 8,
  parameter int INST_W         = 16,
  parameter int D_ADDR_W       = 12,
  parameter int I_ADDR_W       = 12,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                space,
  input  logic [11:0]               start_addr,
  input  logic [12:0]               count,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      debug_enable,
  output logic [REG_ADDR_WIDTH-1:0] reg_debug_addr,
  input  logic [DATA_W-1:0]         reg_debug_rdata,
  output logic [D_ADDR_W-1:0]       dmem_debug_addr,
  input  logic [DATA_W-1:0]         dmem_debug_rdata,
  output logic [I_ADDR_W-1:0]       imem_debug_addr,
  input  logic [INST_W-1:0]         imem_debug_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INST_W-1:0]         out_data,
  output logic [11:0]               out_addr,
  output logic                      out_last
);

  // state  | meaning
  // IDLE   | waiting for start, validates the request
  // ADDR   | address driven onto the selected debug port
  // SAMPLE | debug read settling, rdata captured at end of cycle
  // OUT    | word presented on the stream, waiting for out_ready
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, ADDR, SAMPLE, OUT, DONE} state_t;

  localparam logic [11:0] REG_MASK = 12'((13'd1 << REG_ADDR_WIDTH) - 13'd1);
  localparam logic [11:0] D_MASK   = 12'((13'd1 << D_ADDR_W) - 13'd1);
  localparam logic [11:0] I_MASK   = 12'((13'd1 << I_ADDR_W) - 13'd1);

  state_t      state;
  logic [1:0]  space_q;
  logic [11:0] addr_q;
  logic [12:0] remaining;

  logic                      req_bad;
  logic [1:0]                launch_space;
  logic [11:0]               launch_base;
  logic [11:0]               launch_addr;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_n;
  logic [D_ADDR_W-1:0]       dmem_addr_n;
  logic [I_ADDR_W-1:0]       imem_addr_n;
  logic [INST_W-1:0]         sel_rdata;

  assign req_bad = (space == 2'd3) || (count == 13'd0) ||
                   ((space == 2'd0) && (count > 13'd16)) || (count > 13'd4096);

  // Address for the next ADDR entry: either the fresh start or the next word,
  // wrapped to the width of the space being scanned.
  always_comb begin
    launch_space = (state == IDLE) ? space : space_q;
    launch_base  = (state == IDLE) ? start_addr : addr_q + 12'd1;
    case (launch_space)
      2'd0:    launch_addr = launch_base & REG_MASK;
      2'd1:    launch_addr = launch_base & D_MASK;
      default: launch_addr = launch_base & I_MASK;
    endcase
    reg_addr_n  = '0;
    dmem_addr_n = '0;
    imem_addr_n = '0;
    case (launch_space)
      2'd0:    reg_addr_n  = launch_addr[REG_ADDR_WIDTH-1:0];
      2'd1:    dmem_addr_n = launch_addr[D_ADDR_W-1:0];
      default: imem_addr_n = launch_addr[I_ADDR_W-1:0];
    endcase
  end

  always_comb begin
    case (space_q)
      2'd0:    sel_rdata = INST_W'(reg_debug_rdata);
      2'd1:    sel_rdata = INST_W'(dmem_debug_rdata);
      default: sel_rdata = imem_debug_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      space_q         <= '0;
      addr_q          <= '0;
      remaining       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      debug_enable    <= 1'b0;
      reg_debug_addr  <= '0;
      dmem_debug_addr <= '0;
      imem_debug_addr <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_addr        <= '0;
      out_last        <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (abort && (state == ADDR || state == SAMPLE || state == OUT)) begin
        // Abort outranks a same-cycle handshake and never produces done.
        state           <= IDLE;
        busy            <= 1'b0;
        debug_enable    <= 1'b0;
        out_valid       <= 1'b0;
        reg_debug_addr  <= '0;
        dmem_debug_addr <= '0;
        imem_debug_addr <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (req_bad) begin
                error <= 1'b1;
              end else begin
                state           <= ADDR;
                space_q         <= space;
                addr_q          <= launch_addr;
                remaining       <= count;
                busy            <= 1'b1;
                debug_enable    <= 1'b1;
                reg_debug_addr  <= reg_addr_n;
                dmem_debug_addr <= dmem_addr_n;
                imem_debug_addr <= imem_addr_n;
              end
            end
          end
          ADDR: state <= SAMPLE;
          SAMPLE: begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_data  <= sel_rdata;
            out_addr  <= addr_q;
            out_last  <= (remaining == 13'd1);
          end
          OUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (out_last) begin
                state           <= DONE;
                done            <= 1'b1;
                busy            <= 1'b0;
                debug_enable    <= 1'b0;
                reg_debug_addr  <= '0;
                dmem_debug_addr <= '0;
                imem_debug_addr <= '0;
              end else begin
                state           <= ADDR;
                addr_q          <= launch_addr;
                remaining       <= remaining - 13'd1;
                reg_debug_addr  <= reg_addr_n;
                dmem_debug_addr <= dmem_addr_n;
                imem_debug_addr <= imem_addr_n;
              end
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turtle_debug_scanner.sv
// Directed bench for turtle_debug_scanner with simple memory models on the
// debug read ports.
module tb_turtle_debug_scanner;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [1:0]  space;
  logic [11:0] start_addr;
  logic [12:0] count;
  logic        busy, done, error, debug_enable;
  logic [3:0]  reg_debug_addr;
  logic [7:0]  reg_debug_rdata;
  logic [11:0] dmem_debug_addr;
  logic [7:0]  dmem_debug_rdata;
  logic [11:0] imem_debug_addr;
  logic [15:0] imem_debug_rdata;
  logic        out_valid, out_last;
  logic [15:0] out_data;
  logic [11:0] out_addr;

  logic [7:0] dmem [4096];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // reg[a] = 0x30+a, dmem[a] = a[7:0]^0x5A unless patched, imem[a] = {0xA, a}
  assign reg_debug_rdata  = 8'h30 + {4'h0, reg_debug_addr};
  assign dmem_debug_rdata = dmem[dmem_debug_addr];
  assign imem_debug_rdata = {4'hA, imem_debug_addr};

  turtle_debug_scanner dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .space(space),
    .start_addr(start_addr), .count(count), .busy(busy), .done(done),
    .error(error), .debug_enable(debug_enable),
    .reg_debug_addr(reg_debug_addr), .reg_debug_rdata(reg_debug_rdata),
    .dmem_debug_addr(dmem_debug_addr), .dmem_debug_rdata(dmem_debug_rdata),
    .imem_debug_addr(imem_debug_addr), .imem_debug_rdata(imem_debug_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {26'd0, busy, done, error, debug_enable, out_valid, out_last}, 32'd0);
    chk({tag, "_addrs"}, {reg_debug_addr, dmem_debug_addr, imem_debug_addr}, 32'd0);
    chk({tag, "_odata"}, {4'd0, out_addr, out_data}, 32'd0);
  endtask

  // Called while in ADDR: checks the 3-cycle path up to a presented word.
  task automatic wait_word(input string tag, input logic [15:0] d, input logic [11:0] a,
                           input logic l);
    chk({tag, "_addr_nv"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_addr_busy"}, {30'd0, busy, debug_enable}, 32'd3);
    tick();
    chk({tag, "_samp_nv"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
    chk({tag, "_oaddr"}, {20'd0, out_addr}, {20'd0, a});
    chk({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) dmem[i] = 8'(i) ^ 8'h5A;
    dmem[12'h010] = 8'hA1;
    dmem[12'h011] = 8'hB2;
    dmem[12'h012] = 8'hC3;

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    space = 2'd0; start_addr = 12'd0; count = 13'd0;
    tick(); tick();
    reset = 1'b0;
    chk_all_zero("rst");

    // dmem scan of three words, sink always ready
    space = 2'd1; start_addr = 12'h010; count = 13'd3; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("d_dmem_addr0", {20'd0, dmem_debug_addr}, 32'h010);
    chk("d_unsel_addr", {16'd0, reg_debug_addr, imem_debug_addr}, 32'd0);
    wait_word("d0", 16'h00A1, 12'h010, 1'b0);
    tick();
    chk("d_dmem_addr1", {20'd0, dmem_debug_addr}, 32'h011);
    wait_word("d1", 16'h00B2, 12'h011, 1'b0);
    tick();
    wait_word("d2", 16'h00C3, 12'h012, 1'b1);
    tick();
    chk("d_done", {29'd0, done, busy, out_valid}, 32'b100);
    tick();
    chk("d_done_gone", {31'd0, done}, 32'd0);

    // register scan wrapping 15 -> 0
    space = 2'd0; start_addr = 12'd14; count = 13'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("r_reg_addr0", {28'd0, reg_debug_addr}, 32'd14);
    wait_word("r0", 16'h003E, 12'd14, 1'b0);
    tick();
    wait_word("r1", 16'h003F, 12'd15, 1'b0);
    tick();
    chk("r_reg_wrap", {28'd0, reg_debug_addr}, 32'd0);
    wait_word("r2", 16'h0030, 12'd0, 1'b0);
    tick();
    wait_word("r3", 16'h0031, 12'd1, 1'b1);
    tick();
    chk("r_done", {31'd0, done}, 32'd1);
    tick();

    // imem scan with backpressure, also wraps 4095 -> 0
    space = 2'd2; start_addr = 12'hFFF; count = 13'd2; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_word("i0", 16'hAFFF, 12'hFFF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("i_hold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'hAFFF});
    end
    out_ready = 1'b1;
    tick();
    chk("i_hs_nv", {31'd0, out_valid}, 32'd0);
    chk("i_imem_wrap", {20'd0, imem_debug_addr}, 32'd0);
    wait_word("i1", 16'hA000, 12'h000, 1'b1);
    tick();
    chk("i_done", {31'd0, done}, 32'd1);
    tick();

    // rejected requests
    space = 2'd3; count = 13'd1; start = 1'b1;
    tick();
    chk("e_sp3", {29'd0, error, busy, debug_enable}, 32'b100);
    space = 2'd1; count = 13'd0;
    tick();
    chk("e_cnt0", {29'd0, error, busy, debug_enable}, 32'b100);
    space = 2'd0; count = 13'd17;
    tick();
    chk("e_reg17", {29'd0, error, busy, debug_enable}, 32'b100);
    space = 2'd1; count = 13'd4097;
    tick();
    chk("e_4097", {29'd0, error, busy, debug_enable}, 32'b100);
    start = 1'b0;
    tick();
    chk("e_quiet", {29'd0, error, busy, debug_enable}, 32'd0);

    // abort during SAMPLE of word 2 of 5
    space = 2'd1; start_addr = 12'h100; count = 13'd5; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_word("a0", 16'h005A, 12'h100, 1'b0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("a_idle", {28'd0, done, busy, debug_enable, out_valid}, 32'd0);
    chk("a_addr0", {20'd0, dmem_debug_addr}, 32'd0);
    tick();
    chk("a_no_done", {30'd0, done, busy}, 32'd0);
    space = 2'd1; start_addr = 12'h012; count = 13'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_word("a_new", 16'h00C3, 12'h012, 1'b1);
    tick();
    chk("a_new_done", {31'd0, done}, 32'd1);
    tick();

    // reset while a word is waiting in OUT
    space = 2'd1; start_addr = 12'h011; count = 13'd3; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_word("x0", 16'h00B2, 12'h011, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("x_rst");
    space = 2'd1; start_addr = 12'h020; count = 13'd1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("x_fresh_addr", {20'd0, dmem_debug_addr}, 32'h020);
    wait_word("x1", 16'h007A, 12'h020, 1'b1);
    tick();
    chk("x_done", {31'd0, done}, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
